// File: rtl/instr_prefetch_register.sv
// ============================================================================
// instr_prefetch_register
//   Instruction register fed by a DEPTH-entry prefetch queue, with decoded
//   MIPS fields.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module instr_prefetch_register #(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         inValid,
  input  logic [31:0]                  inData,
  output logic                         inReady,
  input  logic                         IRWre,
  input  logic                         flush,
  output logic [31:0]                  dataOut,
  output logic                         irValid,
  output logic                         irStall,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [5:0]                   opcode,
  output logic [4:0]                   rs,
  output logic [4:0]                   rt,
  output logic [4:0]                   rd,
  output logic [4:0]                   sa,
  output logic [5:0]                   funct,
  output logic [15:0]                  imm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;

  logic empty, full, push, pop, bypass;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // An empty queue hands the offered word straight to the IR instead of storing it.
  assign pop    = ~flush & IRWre & ~empty;
  assign bypass = ~flush & IRWre & empty & inValid;
  assign push   = ~flush & inValid & ~full & ~bypass;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ir_d       = RESET_INSTR;
      ir_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = inData;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        ir_d       = mem_q[rd_ptr_q];
        ir_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end else if (bypass) begin
        ir_d       = inData;
        ir_valid_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ir_q       <= RESET_INSTR;
      ir_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign inReady = ~full;
  assign irStall = IRWre & empty & ~inValid;
  assign count   = count_q;
  assign dataOut = ir_q;
  assign irValid = ir_valid_q;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign sa     = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_register.sv
// ============================================================================
// tb_instr_prefetch_register
//   Directed and randomized bench with a queue-based reference model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_prefetch_register;

  localparam int          DEPTH       = 4;
  localparam logic [31:0] RESET_INSTR = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        inValid, IRWre, flush;
  logic [31:0] inData;
  logic        inReady, irValid, irStall;
  logic [31:0] dataOut;
  logic [2:0]  count;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;

  instr_prefetch_register #(.DEPTH(DEPTH), .RESET_INSTR(RESET_INSTR)) dut (
    .CLK(CLK), .RST(RST), .inValid(inValid), .inData(inData), .inReady(inReady),
    .IRWre(IRWre), .flush(flush), .dataOut(dataOut), .irValid(irValid),
    .irStall(irStall), .count(count), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .sa(sa), .funct(funct), .imm(imm)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  logic [31:0] m_ir;
  logic        m_irv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ir  = RESET_INSTR;
    m_irv = 1'b0;
  endtask

  // Compare every DUT output against the model with the current inputs applied.
  task automatic compare_all();
    chk("count",   32'(count),   32'(mq.size()));
    chk("inReady", 32'(inReady), 32'(mq.size() < DEPTH));
    chk("irStall", 32'(irStall), 32'(IRWre && mq.size() == 0 && !inValid));
    chk("dataOut", dataOut, m_ir);
    chk("irValid", 32'(irValid), 32'(m_irv));
    chk("opcode",  32'(opcode), 32'(m_ir >> 26));
    chk("rs",      32'(rs),     32'((m_ir >> 21) & 32'h1f));
    chk("rt",      32'(rt),     32'((m_ir >> 16) & 32'h1f));
    chk("rd",      32'(rd),     32'((m_ir >> 11) & 32'h1f));
    chk("sa",      32'(sa),     32'((m_ir >> 6) & 32'h1f));
    chk("funct",   32'(funct),  32'(m_ir % 64));
    chk("imm",     32'(imm),    32'(m_ir % 65536));
  endtask

  task automatic model_edge(input logic v, input logic [31:0] d, input logic w, input logic f);
    int  n;
    logic ready;
    n     = mq.size();
    ready = (n < DEPTH);
    if (f) begin
      model_reset();
    end else if (w && n > 0) begin
      m_ir  = mq.pop_front();
      m_irv = 1'b1;
      if (v && ready) mq.push_back(d);
    end else if (w && v) begin
      m_ir  = d;
      m_irv = 1'b1;
    end else if (v && ready) begin
      mq.push_back(d);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic w, input logic f);
    @(negedge CLK);
    inValid = v; inData = d; IRWre = w; flush = f;
    #1;
    compare_all();
    model_edge(v, d, w, f);
  endtask

  task automatic settle();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] words [4];
  logic [31:0] exp_seq[$];

  initial begin
    words[0] = 32'h2001_0005; words[1] = 32'h2002_0007;
    words[2] = 32'h0022_1820; words[3] = 32'hAC03_0000;
    RST = 1'b0; inValid = 1'b0; IRWre = 1'b0; flush = 1'b0; inData = '0;
    model_reset();
    #12;
    chk("rst_count",   32'(count), 32'd0);
    chk("rst_dataOut", dataOut, 32'h0);
    chk("rst_irValid", 32'(irValid), 32'd0);
    chk("rst_inReady", 32'(inReady), 32'd1);
    @(negedge CLK);
    RST = 1'b1;

    // Fill and in-order drain
    for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0, 1'b0);
    settle();
    chk("fill_count",   32'(count), 32'd4);
    chk("fill_inReady", 32'(inReady), 32'd0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    settle();
    chk("fifth_ignored", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      settle();
      chk("drain_word", dataOut, words[i]);
      if (i == 2) begin
        chk("f_opcode", 32'(opcode), 32'd0);
        chk("f_rs",     32'(rs),     32'd1);
        chk("f_rt",     32'(rt),     32'd2);
        chk("f_rd",     32'(rd),     32'd3);
        chk("f_funct",  32'(funct),  32'h20);
      end
    end

    // Bypass then stall
    step(1'b1, 32'h0800_0010, 1'b1, 1'b0);
    settle();
    chk("bypass_data",  dataOut, 32'h0800_0010);
    chk("bypass_count", 32'(count), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_flag", 32'(irStall), 32'd1);
    settle();
    chk("stall_hold", dataOut, 32'h0800_0010);

    // Simultaneous push/pop across pointer wrap
    step(1'b1, 32'hA000_0000, 1'b0, 1'b0);
    step(1'b1, 32'hA000_0001, 1'b0, 1'b0);
    exp_seq.delete();
    exp_seq.push_back(32'hA000_0000);
    exp_seq.push_back(32'hA000_0001);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 32'hB000_0000 + 32'(k), 1'b1, 1'b0);
      exp_seq.push_back(32'hB000_0000 + 32'(k));
      settle();
      chk("pp_count", 32'(count), 32'd2);
      chk("pp_data",  dataOut, exp_seq.pop_front());
    end

    // Full with pop: inReady lags by one cycle
    step(1'b1, 32'hC000_0000, 1'b0, 1'b0);
    step(1'b1, 32'hC000_0001, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fullpop_ready_same", 32'(inReady), 32'd0);
    settle();
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_ready_next", 32'(inReady), 32'd1);

    // Flush with IRWre and push in the same cycle
    step(1'b1, 32'hFFFF_0000, 1'b1, 1'b1);
    settle();
    chk("flush_count",   32'(count), 32'd0);
    chk("flush_data",    dataOut, RESET_INSTR);
    chk("flush_irValid", 32'(irValid), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    settle();
    chk("flush_dropped", dataOut, RESET_INSTR);

    // Asynchronous reset mid-run with count=3
    for (int i = 0; i < 3; i++) step(1'b1, words[i], 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    chk("arst_count",   32'(count), 32'd0);
    chk("arst_data",    dataOut, 32'h0);
    chk("arst_irValid", 32'(irValid), 32'd0);
    chk("arst_inReady", 32'(inReady), 32'd1);
    @(negedge CLK);
    RST = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 19) == 0));
    end
    @(negedge CLK);
    #1;
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_prefetch_register.md
# instr_prefetch_register

Parametrised instruction register with a DEPTH-entry prefetch queue for the multicycle CPU datapath. Fetched words are pushed into the queue with a valid/ready handshake. The control unit loads the head word into the architectural IR with its IR write-enable; a flush discards all prefetched words on a taken branch or jump. The block presents the current instruction plus its decoded MIPS fields to the control unit and register file.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, at least 2
- RESET_INSTR, 32'h0000_0000, IR value after reset and after flush (NOP)

- CLK  input  1  clock; all state updates on posedge
- RST  input  1  asynchronous, active-low reset
- inValid  input  1  a fetched word is offered on inData
- inData  input  32  fetched instruction word
- inReady  output  1  queue can accept; equals (count < DEPTH)
- IRWre  input  1  control unit requests an IR load this cycle
- flush  input  1  discard queue contents and invalidate IR
- dataOut  output  32  current IR contents
- irValid  output  1  dataOut holds a valid fetched instruction
- irStall  output  1  combinational: IRWre & (count==0) & ~inValid
- count  output  $clog2(DEPTH+1)  queue occupancy
- opcode  output  6  dataOut[31:26]
- rs  output  5  dataOut[25:21]
- rt  output  5  dataOut[20:16]
- rd  output  5  dataOut[15:11]
- sa  output  5  dataOut[10:6]
- funct  output  6  dataOut[5:0]
- imm  output  16  dataOut[15:0]

## Operation
- Reset (RST=0, any time, independent of CLK): queue emptied (read/write pointers 0, count 0), dataOut=RESET_INSTR, irValid=0. Decoded fields follow dataOut. inReady=1 and irStall=0 unless IRWre is high.
- Push: a word is accepted when inValid & inReady. No pass-through when full: inValid while count==DEPTH is ignored, and the source holds the word.
- IR load when IRWre=1, in priority order:
  - count>0: dataOut←head, irValid←1, pop head.
  - count==0 & inValid: bypass. dataOut←inData, irValid←1; the word is consumed and not stored.
  - count==0 & ~inValid: stall. dataOut and irValid hold; irStall=1.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged. The pushed word goes to the tail and the head goes to the IR.
- When full, an IRWre pop frees one entry. inReady stays 0 in that cycle and rises the next cycle.
- Pointers wrap modulo DEPTH; count saturates by construction, never above DEPTH and never below 0.
- flush has top priority. At the next edge: queue emptied, dataOut=RESET_INSTR, irValid=0. IRWre and any push in the same cycle are ignored. inReady is not gated by flush, so the source must treat a push during flush as dropped.
- Without IRWre, dataOut holds indefinitely, which is the multicycle CPU requirement.

## Timing
- Push-to-queue: 1 cycle; count updates at the accepting edge.
- IR load latency: dataOut and fields are valid immediately after the IRWre edge. The first instruction after reset is available one edge after IRWre via bypass.
- Fields are purely combinational from the dataOut register; no added latency.
- inReady, irStall and count are derived from registered state, except irStall, which also depends combinationally on the inputs IRWre and inValid.
- Reset deassertion takes effect at the next edge with no extra synchronisation; the top level supplies a synchronously deasserted RST.

## Test plan
- Reset: drive RST=0 mid-run with count=3 → immediately count=0, dataOut=32'h0, irValid=0, inReady=1.
- Fill and order: push 32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hAC03_0000 (DEPTH=4) → count=4, inReady=0. A fifth push is ignored. Four IRWre cycles yield the words in order. After the third load, opcode=0, rs=1, rt=2, rd=3, funct=6'h20.
- Bypass and stall: from empty, IRWre with inValid and inData=32'h0800_0010 → next edge dataOut=32'h0800_0010 with count=0. Then IRWre with inValid=0 → irStall=1 and dataOut unchanged.
- Simultaneous push and pop: count=2, IRWre with a push → count stays 2, the head goes to the IR, and FIFO order is preserved across a pointer wrap (run 10 such cycles).
- Full with pop: count=4, IRWre → count=3; inReady is 0 during that cycle and 1 the next.
- Flush: count=3, irValid=1, assert flush with IRWre and inValid → next edge count=0, dataOut=RESET_INSTR, irValid=0, and the pushed word is absent.
